// File: rtl/shift_rx.sv
// shift_rx: serial-to-parallel receiver for the shifter link.
// Rebuilds MSB-first words delimited by an end-of-shift strobe, presents
// them on Q with a valid/ack handshake, and tracks frame alignment.
module shift_rx #(
  parameter int bits = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sin,
  input  logic            eos,
  input  logic            ack,
  output logic [bits-1:0] Q,
  output logic            valid,
  output logic            sync,
  output logic            ovr,
  output logic            ferr
);

  localparam int CW = $clog2(bits);
  localparam logic [CW-1:0] LAST = CW'(bits - 1);

  // RUN: aligned to frames. HUNT: waiting for an eos to realign.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HUNT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [bits-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [bits-1:0] word_q, word_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;

  logic [bits-1:0] sr_shifted;
  logic            last_bit;
  logic            word_done;

  assign sr_shifted = {sr_q[bits-2:0], sin};
  assign last_bit   = (cnt_q == LAST);

  // Next-state logic: framing, word capture and the consumer handshake.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a signal unassigned;
    // without these defaults the tool would infer latches.
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ferr_d    = ferr_q;
    word_done = 1'b0;

    if (en) begin
      unique case (state_q)
        ST_RUN: begin
          sr_d = sr_shifted;
          if (eos && last_bit) begin
            // Good word: the last bit goes straight into Q on this edge.
            word_d    = sr_shifted;
            word_done = 1'b1;
            cnt_d     = '0;
          end else if (eos) begin
            // Short frame: drop it, but eos still marks a frame boundary.
            ferr_d = 1'b1;
            cnt_d  = '0;
          end else if (last_bit) begin
            // A full word went by without eos: alignment is lost.
            ferr_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_HUNT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HUNT: begin
          // The bit carrying eos closes the unknown frame and is dropped.
          if (eos) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_HUNT;
          cnt_d   = '0;
        end
      endcase
    end

    // Handshake: a new word always leaves valid set; overwriting an
    // unacknowledged word is an overrun unless it is acked on this edge.
    if (word_done) begin
      valid_d = 1'b1;
      if (valid_q && !ack) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_RUN;
      sr_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign Q     = word_q;
  assign valid = valid_q;
  assign sync  = (state_q == ST_RUN);
  assign ovr   = ovr_q;
  assign ferr  = ferr_q;

endmodule
